sll_seq: RTL

Sequential shift-logical-left unit, the left-direction counterpart of the catalog's shift-logical-right element. It shifts one bit position per clock, so a shift by k takes k cycles. It has a valid/ready request port and a valid/ready result port, so the datapath or a multi-cycle ALU controller can issue a shift and stall on the result. It is an area-cheap alternative to a barrel shifter for catalog CPUs.

---
 rtl/sll_seq.sv | 74 +++++++
 1 files changed

// File: rtl/sll_seq.sv
// Sequential logical left shifter: one bit position per clock, valid/ready on
// both the request and the result side.
module sll_seq #(
    parameter  int N       = 32,
    localparam int SHAMT_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       y,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state;
    logic [N-1:0]       sreg;
    logic [SHAMT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sreg      <= '0;
            cnt       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sreg     <= a;
                        cnt      <= shamt;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (shamt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sreg <= {sreg[N-2:0], 1'b0};
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First DONE cycle registers the result; the handshake
                    // is only honoured once out_valid is visible.
                    if (!out_valid) begin
                        y         <= sreg;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
